// File: rtl/mem_arbiter_ctrl_if.sv
// Bus bundle between the LSU-facing arbiter and the single-port memory.
// The master modport is the arbiter; the slave modport is the LSU/memory environment.
interface mem_arbiter_ctrl_if #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4
);
   logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
   logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
   logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
   logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
   logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
   logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

   logic                 mem_read_valid;
   logic [ADDR_BITS-1:0] mem_read_address;
   logic                 mem_read_ready;
   logic [DATA_BITS-1:0] mem_read_data;
   logic                 mem_write_valid;
   logic [ADDR_BITS-1:0] mem_write_address;
   logic [DATA_BITS-1:0] mem_write_data;
   logic                 mem_write_ready;

   modport master (
      input  consumer_read_valid, consumer_read_address,
      input  consumer_write_valid, consumer_write_address, consumer_write_data,
      input  mem_read_ready, mem_read_data, mem_write_ready,
      output consumer_read_ready, consumer_read_data, consumer_write_ready,
      output mem_read_valid, mem_read_address,
      output mem_write_valid, mem_write_address, mem_write_data
   );

   modport slave (
      output consumer_read_valid, consumer_read_address,
      output consumer_write_valid, consumer_write_address, consumer_write_data,
      output mem_read_ready, mem_read_data, mem_write_ready,
      input  consumer_read_ready, consumer_read_data, consumer_write_ready,
      input  mem_read_valid, mem_read_address,
      input  mem_write_valid, mem_write_address, mem_write_data
   );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter sharing one single-port memory among NUM_CONSUMERS LSUs.
// One transaction in flight; every output is registered.
module mem_arbiter_ctrl #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4,
   parameter int IDX_BITS      = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_arbiter_ctrl_if.master bus,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

   state_t                   state;
   logic [IDX_BITS-1:0]      last_grant;
   logic [IDX_BITS-1:0]      grant_idx;
   logic [NUM_CONSUMERS-1:0] rd_ready;
   logic [NUM_CONSUMERS-1:0] wr_ready;
   logic [NUM_CONSUMERS-1:0] req;
   logic [DATA_BITS-1:0]     rd_data [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0]     rd_addr [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0]     wr_addr [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]     wr_data [NUM_CONSUMERS];

   logic                 mem_rd_vld;
   logic [ADDR_BITS-1:0] mem_rd_addr;
   logic                 mem_wr_vld;
   logic [ADDR_BITS-1:0] mem_wr_addr;
   logic [DATA_BITS-1:0] mem_wr_data;

   logic                found;
   logic [IDX_BITS-1:0] winner;
   logic [IDX_BITS-1:0] scan_idx;

   for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_slot
      assign rd_addr[i] = bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
      assign wr_addr[i] = bus.consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
      assign wr_data[i] = bus.consumer_write_data[i*DATA_BITS +: DATA_BITS];
      assign bus.consumer_read_data[i*DATA_BITS +: DATA_BITS] = rd_data[i];
   end

   assign req                      = bus.consumer_read_valid | bus.consumer_write_valid;
   assign bus.consumer_read_ready  = rd_ready;
   assign bus.consumer_write_ready = wr_ready;
   assign bus.mem_read_valid       = mem_rd_vld;
   assign bus.mem_read_address     = mem_rd_addr;
   assign bus.mem_write_valid      = mem_wr_vld;
   assign bus.mem_write_address    = mem_wr_addr;
   assign bus.mem_write_data       = mem_wr_data;

   // Scan starts one past the last winner and wraps, so the first hit is the fair choice.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = last_grant;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
         if (scan_idx == IDX_BITS'(NUM_CONSUMERS-1)) scan_idx = '0;
         else                                        scan_idx = scan_idx + IDX_BITS'(1);
         if (!found && req[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         last_grant  <= IDX_BITS'(NUM_CONSUMERS-1);
         grant_idx   <= '0;
         rd_ready    <= '0;
         wr_ready    <= '0;
         mem_rd_vld  <= 1'b0;
         mem_rd_addr <= '0;
         mem_wr_vld  <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         busy        <= 1'b0;
         for (int i = 0; i < NUM_CONSUMERS; i++) rd_data[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  last_grant <= winner;
                  grant_idx  <= winner;
                  busy       <= 1'b1;
                  // A consumer raising both valids gets its read; the write waits for re-request.
                  if (bus.consumer_read_valid[winner]) begin
                     mem_rd_addr <= rd_addr[winner];
                     mem_rd_vld  <= 1'b1;
                     state       <= READ_WAIT;
                  end else begin
                     mem_wr_addr <= wr_addr[winner];
                     mem_wr_data <= wr_data[winner];
                     mem_wr_vld  <= 1'b1;
                     state       <= WRITE_WAIT;
                  end
               end
            end
            READ_WAIT: begin
               if (bus.mem_read_ready) begin
                  rd_data[grant_idx]  <= bus.mem_read_data;
                  mem_rd_vld          <= 1'b0;
                  rd_ready[grant_idx] <= 1'b1;
                  state               <= RELAY;
               end
            end
            WRITE_WAIT: begin
               if (bus.mem_write_ready) begin
                  mem_wr_vld          <= 1'b0;
                  wr_ready[grant_idx] <= 1'b1;
                  state               <= RELAY;
               end
            end
            RELAY: begin
               if ((rd_ready[grant_idx] && !bus.consumer_read_valid[grant_idx]) ||
                   (wr_ready[grant_idx] && !bus.consumer_write_valid[grant_idx])) begin
                  rd_ready <= '0;
                  wr_ready <= '0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl with a combinational-read memory model.
module tb_mem_arbiter_ctrl;
   localparam int A = 8;
   localparam int D = 8;
   localparam int N = 4;

   logic clk;
   logic reset_n;
   logic busy;
   int   n_tests;
   int   n_fail;
   int   wr_count;
   int   wc;
   int   order [4];
   int   order_n;
   logic multi;
   logic [7:0] mem [256];

   mem_arbiter_ctrl_if #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) bus ();

   mem_arbiter_ctrl #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N), .IDX_BITS(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_read_data = mem[bus.mem_read_address];

   always @(posedge clk) begin
      if (bus.mem_write_valid) begin
         mem[bus.mem_write_address] <= bus.mem_write_data;
         wr_count <= wr_count + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rd_slot(input int i);
      return bus.consumer_read_data[i*D +: D];
   endfunction

   // Full read by one consumer against an always-ready memory, ready held one extra cycle.
   task automatic single_read(input int idx, input logic [7:0] addr, input logic [7:0] exp);
      bus.consumer_read_address[idx*A +: A] = addr;
      bus.consumer_read_valid[idx] = 1'b1;
      tick();
      check("rd_mem_valid", 32'(bus.mem_read_valid), 32'd1);
      check("rd_mem_addr", 32'(bus.mem_read_address), 32'(addr));
      check("rd_ready_early", 32'(bus.consumer_read_ready), 32'd0);
      tick();
      check("rd_ready", 32'(bus.consumer_read_ready), 32'd1 << idx);
      check("rd_data", 32'(rd_slot(idx)), 32'(exp));
      check("rd_mem_valid_drop", 32'(bus.mem_read_valid), 32'd0);
      tick();
      check("rd_ready_hold", 32'(bus.consumer_read_ready), 32'd1 << idx);
      bus.consumer_read_valid[idx] = 1'b0;
      tick();
      check("rd_ready_clear", 32'(bus.consumer_read_ready), 32'd0);
      check("rd_busy_clear", 32'(busy), 32'd0);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      wr_count = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[10] = 8'h05;
      mem[11] = 8'h21;
      mem[12] = 8'h32;
      mem[13] = 8'h43;

      reset_n                    = 1'b0;
      bus.consumer_read_valid    = '0;
      bus.consumer_read_address  = '0;
      bus.consumer_write_valid   = '0;
      bus.consumer_write_address = '0;
      bus.consumer_write_data    = '0;
      bus.mem_read_ready         = 1'b1;
      bus.mem_write_ready        = 1'b1;

      // 1: reset with every consumer requesting; consumer 0 must win first
      for (int i = 0; i < N; i++) bus.consumer_read_address[i*A +: A] = 8'(10 + i);
      bus.consumer_read_valid = 4'hF;
      tick();
      tick();
      check("rst_rd_ready", 32'(bus.consumer_read_ready), 32'd0);
      check("rst_wr_ready", 32'(bus.consumer_write_ready), 32'd0);
      check("rst_mem_rd_valid", 32'(bus.mem_read_valid), 32'd0);
      check("rst_mem_wr_valid", 32'(bus.mem_write_valid), 32'd0);
      check("rst_mem_rd_addr", 32'(bus.mem_read_address), 32'd0);
      check("rst_rd_data", bus.consumer_read_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      tick();
      check("first_grant_valid", 32'(bus.mem_read_valid), 32'd1);
      check("first_grant_addr", 32'(bus.mem_read_address), 32'd10);
      check("first_grant_busy", 32'(busy), 32'd1);
      bus.consumer_read_valid = '0;
      tick();
      check("first_grant_ready", 32'(bus.consumer_read_ready), 32'd1);
      check("first_grant_data", 32'(rd_slot(0)), 32'h05);
      tick();
      check("first_grant_idle", 32'(busy), 32'd0);

      // 2: consumer 2 reads addr 10
      single_read(2, 8'd10, 8'h05);

      // 3: consumer 1 writes 12 to addr 14, consumer 0 reads it back
      wc = wr_count;
      bus.consumer_write_address[1*A +: A] = 8'd14;
      bus.consumer_write_data[1*D +: D]    = 8'd12;
      bus.consumer_write_valid[1]          = 1'b1;
      tick();
      check("wr_mem_valid", 32'(bus.mem_write_valid), 32'd1);
      check("wr_mem_addr", 32'(bus.mem_write_address), 32'd14);
      check("wr_mem_data", 32'(bus.mem_write_data), 32'd12);
      check("wr_ready_early", 32'(bus.consumer_write_ready), 32'd0);
      tick();
      check("wr_mem_valid_drop", 32'(bus.mem_write_valid), 32'd0);
      check("wr_ready", 32'(bus.consumer_write_ready), 32'b0010);
      check("wr_single_write", 32'(wr_count - wc), 32'd1);
      bus.consumer_write_valid[1] = 1'b0;
      tick();
      check("wr_ready_clear", 32'(bus.consumer_write_ready), 32'd0);
      single_read(0, 8'd14, 8'd12);

      // consumer 3 goes next so the pointer sits at 3 before the fairness run
      single_read(3, 8'd13, 8'h43);
      check("slot0_held", 32'(rd_slot(0)), 32'd12);

      // 4: all consumers request together, each drops valid once its ready is seen
      for (int i = 0; i < N; i++) bus.consumer_read_address[i*A +: A] = 8'(10 + i);
      bus.consumer_read_valid = 4'hF;
      order_n = 0;
      multi   = 1'b0;
      for (int cyc = 0; cyc < 60 && order_n < 4; cyc++) begin
         tick();
         if ($countones(bus.consumer_read_ready) > 1) multi = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (bus.consumer_read_ready[i] && bus.consumer_read_valid[i]) begin
               if (order_n < 4) order[order_n] = i;
               order_n++;
               bus.consumer_read_valid[i] = 1'b0;
            end
         end
      end
      tick();
      tick();
      check("rr_grant_count", 32'(order_n), 32'd4);
      for (int k = 0; k < 4; k++) check("rr_order", 32'(order[k]), 32'(k));
      check("rr_one_ready", 32'(multi), 32'd0);
      check("rr_data0", 32'(rd_slot(0)), 32'h05);
      check("rr_data1", 32'(rd_slot(1)), 32'h21);
      check("rr_data2", 32'(rd_slot(2)), 32'h32);
      check("rr_data3", 32'(rd_slot(3)), 32'h43);

      // 5: memory stalls the read for three cycles
      bus.mem_read_ready = 1'b0;
      bus.consumer_read_address[1*A +: A] = 8'd11;
      bus.consumer_read_valid[1] = 1'b1;
      tick();
      for (int s = 0; s < 3; s++) begin
         tick();
         check("stall_mem_valid", 32'(bus.mem_read_valid), 32'd1);
         check("stall_mem_addr", 32'(bus.mem_read_address), 32'd11);
         check("stall_ready", 32'(bus.consumer_read_ready), 32'd0);
      end
      bus.mem_read_ready = 1'b1;
      tick();
      check("stall_done_ready", 32'(bus.consumer_read_ready), 32'b0010);
      check("stall_done_data", 32'(rd_slot(1)), 32'h21);
      bus.consumer_read_valid[1] = 1'b0;
      tick();
      check("stall_idle", 32'(busy), 32'd0);

      // 6: reset lands while a write is waiting on the memory
      bus.mem_write_ready = 1'b0;
      bus.consumer_write_address[2*A +: A] = 8'd20;
      bus.consumer_write_data[2*D +: D]    = 8'h77;
      bus.consumer_write_valid[2]          = 1'b1;
      tick();
      check("rstw_valid", 32'(bus.mem_write_valid), 32'd1);
      tick();
      check("rstw_valid_hold", 32'(bus.mem_write_valid), 32'd1);
      reset_n = 1'b0;
      tick();
      check("rstw_valid_drop", 32'(bus.mem_write_valid), 32'd0);
      check("rstw_busy", 32'(busy), 32'd0);
      check("rstw_ready", 32'(bus.consumer_write_ready), 32'd0);
      wc = wr_count;
      bus.consumer_write_valid = '0;
      tick();
      reset_n = 1'b1;
      bus.mem_write_ready = 1'b1;
      tick();
      tick();
      check("rstw_no_write", 32'(wr_count - wc), 32'd0);
      check("rstw_still_idle", 32'(busy), 32'd0);
      check("rstw_valid_low", 32'(bus.mem_write_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
